// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register built as a 2-entry in-order FIFO (head + skid slot).
// in_ready depends only on registered state, so there is no ready path through this stage.
module wb_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_WBP,
    input  logic              rst_WBP,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_AW-1:0] dst_in,
    input  logic [1:0]        wb_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_AW-1:0] dst_out,
    output logic              regwrite_out,
    output logic              memtoreg_out,
    output logic [DATA_W-1:0] wb_value,
    input  logic [REG_AW-1:0] fwd_src_a,
    input  logic [REG_AW-1:0] fwd_src_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] dst;
        logic              rw;
        logic              m2r;
    } entry_t;

    entry_t head_q, head_d, skid_q, skid_d, in_entry;
    logic   head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic   accept, drain;

    assign in_ready = ~skid_vld_q;
    assign accept   = in_valid & in_ready;
    assign drain    = head_vld_q & out_ready;

    always_comb begin
        in_entry.data = data_in;
        in_entry.alu  = alu_in;
        in_entry.dst  = dst_in;
        // Register 0 is hardwired, so a write to it is dropped at capture.
        in_entry.rw   = wb_in[1] & (dst_in != '0);
        in_entry.m2r  = wb_in[0];
    end

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (drain) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (head_vld_q) begin
            if (accept && drain) begin
                head_d = in_entry;
            end else if (accept) begin
                skid_d     = in_entry;
                skid_vld_d = 1'b1;
            end else if (drain) begin
                head_vld_d = 1'b0;
            end
        end else if (accept) begin
            head_d     = in_entry;
            head_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_WBP) begin
        if (rst_WBP) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid    = head_vld_q;
    assign data_out     = head_q.data;
    assign alu_out      = head_q.alu;
    assign dst_out      = head_q.dst;
    assign regwrite_out = head_q.rw & head_vld_q;
    assign memtoreg_out = head_q.m2r;
    assign wb_value     = head_q.m2r ? head_q.data : head_q.alu;
    assign fwd_hit_a    = regwrite_out & (head_q.dst != '0) & (head_q.dst == fwd_src_a);
    assign fwd_hit_b    = regwrite_out & (head_q.dst != '0) & (head_q.dst == fwd_src_b);
    assign occupancy    = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: directed scenarios then random traffic, all checked
// against a queue-based model of the FIFO.
module tb_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic [31:0] alu_in = '0;
    logic [4:0]  dst_in = '0;
    logic [1:0]  wb_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out, alu_out, wb_value;
    logic [4:0]  dst_out;
    logic        regwrite_out, memtoreg_out;
    logic [4:0]  fwd_src_a = '0;
    logic [4:0]  fwd_src_b = '0;
    logic        fwd_hit_a, fwd_hit_b;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    wb_pipe_reg dut (
        .clk_WBP     (clk),
        .rst_WBP     (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .alu_in      (alu_in),
        .dst_in      (dst_in),
        .wb_in       (wb_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .alu_out     (alu_out),
        .dst_out     (dst_out),
        .regwrite_out(regwrite_out),
        .memtoreg_out(memtoreg_out),
        .wb_value    (wb_value),
        .fwd_src_a   (fwd_src_a),
        .fwd_src_b   (fwd_src_b),
        .fwd_hit_a   (fwd_hit_a),
        .fwd_hit_b   (fwd_hit_b),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        logic [4:0]  dst;
        logic        rw;
        logic        m2r;
    } ent_t;

    ent_t q[$];
    ent_t shown = '{d: '0, a: '0, dst: '0, rw: 1'b0, m2r: 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies the current inputs to the model as the coming edge would.
    task automatic model_update();
        ent_t e;
        bit acc, drn;
        if (rst) begin
            q.delete();
            shown = '{d: '0, a: '0, dst: '0, rw: 1'b0, m2r: 1'b0};
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.d = data_in; e.a = alu_in; e.dst = dst_in;
                e.rw = wb_in[1] && (dst_in != 0);
                e.m2r = wb_in[0];
                q.push_back(e);
            end
            if (q.size() > 0) shown = q[0];
        end
    endtask

    task automatic check_all();
        logic v;
        logic rw;
        v  = q.size() > 0;
        rw = v && shown.rw;
        chk("out_valid", out_valid, v);
        chk("in_ready", in_ready, q.size() < 2);
        chk("occupancy", occupancy, q.size());
        chk("data_out", data_out, shown.d);
        chk("alu_out", alu_out, shown.a);
        chk("dst_out", dst_out, shown.dst);
        chk("regwrite_out", regwrite_out, rw);
        chk("memtoreg_out", memtoreg_out, shown.m2r);
        chk("wb_value", wb_value, shown.m2r ? shown.d : shown.a);
        chk("fwd_hit_a", fwd_hit_a, rw && shown.dst != 0 && shown.dst == fwd_src_a);
        chk("fwd_hit_b", fwd_hit_b, rw && shown.dst != 0 && shown.dst == fwd_src_b);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic offer(input logic [31:0] d, input logic [31:0] a, input logic [4:0] dst,
                         input logic [1:0] wb);
        in_valid = 1'b1; data_in = d; alu_in = a; dst_in = dst; wb_in = wb;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_value", wb_value, 0);
        rst = 1'b0;

        // Single entry, accept then drain
        out_ready = 1'b1;
        offer(32'hAAAA0001, 32'h10, 5'd5, 2'b11);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_wbv", wb_value, 32'hAAAA0001);
        chk("single_rw", regwrite_out, 1);
        in_valid = 1'b0;
        step();
        chk("single_drained", out_valid, 0);

        // Backpressure: third entry held upstream, then in-order drain
        out_ready = 1'b0;
        offer(32'h1, 32'h11, 5'd1, 2'b10);
        step();
        offer(32'h2, 32'h22, 5'd2, 2'b10);
        step();
        offer(32'h3, 32'h33, 5'd3, 2'b10);
        step();
        chk("bp_occ", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", dst_out, 1);
        out_ready = 1'b1;
        step();
        chk("bp_drain1", dst_out, 2);
        step();
        chk("bp_drain2", dst_out, 3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", occupancy, 0);

        // Write to register 0 is suppressed
        out_ready = 1'b0; fwd_src_a = 5'd0;
        offer(32'h5, 32'h6, 5'd0, 2'b10);
        step();
        chk("zero_rw", regwrite_out, 0);
        chk("zero_fwd", fwd_hit_a, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Forwarding compare
        out_ready = 1'b0; fwd_src_a = 5'd7; fwd_src_b = 5'd8;
        offer(32'h7, 32'h77, 5'd7, 2'b10);
        step();
        chk("fwd_a_hit", fwd_hit_a, 1);
        chk("fwd_b_miss", fwd_hit_b, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fwd_a_idle", fwd_hit_a, 0);
        chk("fwd_b_idle", fwd_hit_b, 0);

        // Flush with simultaneous accept drops the offered entry
        out_ready = 1'b0;
        offer(32'h9, 32'h99, 5'd9, 2'b11);
        step();
        flush = 1'b1;
        offer(32'hA, 32'hAA, 5'd10, 2'b11);
        step();
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_lost", out_valid, 0);

        // Reset with two entries held
        offer(32'hB, 32'hBB, 5'd11, 2'b11);
        step();
        offer(32'hC, 32'hCC, 5'd12, 2'b11);
        step();
        chk("mid_occ2", occupancy, 2);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_wbv", wb_value, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 15) == 0;
            rst       = $urandom_range(0, 63) == 0;
            data_in   = $urandom;
            alu_in    = $urandom;
            dst_in    = 5'($urandom_range(0, 7));
            wb_in     = 2'($urandom_range(0, 3));
            fwd_src_a = 5'($urandom_range(0, 7));
            fwd_src_b = 5'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the memory-data and ALU-result paths.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning the width of the destination register address.
REQ-003 The block SHALL have port clk_WBP  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_WBP  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  upstream (MEM stage) entry valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-007 The block SHALL have port data_in  input  DATA_W  memory read data.
REQ-008 The block SHALL have port alu_in  input  DATA_W  ALU result.
REQ-009 The block SHALL have port dst_in  input  REG_AW  destination register address.
REQ-010 The block SHALL have port wb_in  input  2  WB controls: bit 1 = RegWrite, bit 0 = MemtoReg.
REQ-011 The block SHALL have port flush  input  1  discard all held entries.
REQ-012 The block SHALL have port out_valid  output  1  head entry valid toward WB.
REQ-013 The block SHALL have port out_ready  input  1  WB consumes the head entry this cycle.
REQ-014 The block SHALL have ports data_out, alu_out (DATA_W) and dst_out (REG_AW)  output  head entry payload.
REQ-015 The block SHALL have ports regwrite_out and memtoreg_out  output  1  head entry controls.
REQ-016 The block SHALL have port wb_value  output  DATA_W  memtoreg_out ? data_out : alu_out.
REQ-017 The block SHALL have ports fwd_src_a and fwd_src_b  input  REG_AW  ID/EX source addresses for forwarding compare.
REQ-018 The block SHALL have ports fwd_hit_a and fwd_hit_b  output  1  forwarding match flags.
REQ-019 The block SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-020 The block SHALL behave as a 2-entry in-order FIFO, made up of a head slot and a skid slot, for the tuple {data, alu, dst, RegWrite, MemtoReg}.
REQ-021 Accept SHALL occur when in_valid & in_ready at a rising edge.
REQ-022 Drain SHALL occur when out_valid & out_ready at a rising edge.
REQ-023 in_ready SHALL equal NOT skid-slot-valid, driven only from registered state with no combinational path from out_ready.
REQ-024 Latency SHALL be one cycle: an entry accepted at edge N SHALL appear on the outputs after edge N, with no combinational input-to-output path.
REQ-025 On accept only at occupancy 0, the entry SHALL go to the head slot; at occupancy 1, the entry SHALL go to the skid slot.
REQ-026 On drain only at occupancy 2, the skid slot SHALL move to the head slot; at occupancy 1, the head slot SHALL become invalid.
REQ-027 On simultaneous accept and drain at occupancy 1, the new entry SHALL go to the head slot and occupancy SHALL stay 1; this case cannot arise at occupancy 2.
REQ-028 While out_valid=1 and out_ready=0, the head payload SHALL remain stable.
REQ-029 An entry with dst_in=0 SHALL be captured with RegWrite forced to 0, since writes to register 0 are suppressed.
REQ-030 regwrite_out SHALL equal stored RegWrite AND out_valid; memtoreg_out SHALL be the stored value.
REQ-031 fwd_hit_x SHALL equal out_valid & regwrite_out & (dst_out != 0) & (dst_out == fwd_src_x), and SHALL be combinational.
REQ-032 Flush SHALL clear both valid bits at the next edge, take priority over accept and drain in the same cycle, and drop the input offered that cycle.
REQ-033 The payload registers SHALL hold their values on flush.
REQ-034 occupancy SHALL equal head-valid + skid-valid.

Reset
REQ-035 While rst_WBP=1 at an edge, all valid bits SHALL clear, and data_out, alu_out, dst_out and the stored controls SHALL load 0.
REQ-036 Reset SHALL take priority over flush, accept and drain.
REQ-037 After the reset edge, the outputs SHALL be out_valid=0, in_ready=1, occupancy=0, regwrite_out=0, wb_value=0 and fwd_hit_a/b=0.
REQ-038 Reset asserted mid-operation with occupancy 2 SHALL discard both entries within one edge.

Verification
REQ-039 The bench SHALL cover single entry: accept {data=0xAAAA0001, alu=0x00000010, dst=5, wb=2'b11} with out_ready=1 -> the next cycle shows out_valid=1, wb_value=0xAAAA0001 and regwrite_out=1, and the entry is drained the cycle after.
REQ-040 The bench SHALL cover backpressure: out_ready=0 with 3 entries offered back-to-back -> 2 accepted, occupancy=2, in_ready=0, and the third held upstream; raising out_ready then drains them in order.
REQ-041 The bench SHALL cover the zero-register write: accept dst=0, wb=2'b10 -> regwrite_out=0, and fwd_hit_a=0 with fwd_src_a=0.
REQ-042 The bench SHALL cover forwarding: head holds dst=7 with RegWrite=1, fwd_src_a=7, fwd_src_b=8 -> fwd_hit_a=1 and fwd_hit_b=0; with out_valid=0 -> both are 0.
REQ-043 The bench SHALL cover flush with accept: occupancy=1 with flush=1 and in_valid=1 in the same cycle -> the next cycle has occupancy=0 and out_valid=0, and the offered entry is lost.
REQ-044 The bench SHALL cover reset mid-stream: occupancy=2 with rst_WBP=1 for one edge -> all outputs are 0 and in_ready=1 after that edge.
